// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: valid/ready word load, MSB-first shift on x, zero-gap back-to-back words.
// Optional PARITY_BIT_EN appends an even-parity bit after each word.
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef PARITY_BIT_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             last_data;
  logic             final_cyc;
  logic             accept;
`ifdef PARITY_BIT_EN
  logic             par;
`endif

  assign last_data = (state == SHIFT) && (cnt == CW'(WIDTH-1));
`ifdef PARITY_BIT_EN
  assign final_cyc = (state == PARITY);
`else
  assign final_cyc = last_data;
`endif

  // Ready is suppressed during reset so nothing looks acceptable to the source.
  assign load_ready = en & ~RESET & ((state == IDLE) | final_cyc);
  assign accept     = load_valid & load_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      x         <= 1'b0;
      x_valid   <= 1'b0;
      word_done <= 1'b0;
`ifdef PARITY_BIT_EN
      par       <= 1'b0;
`endif
    end else if (en) begin
      if (accept) begin
        state     <= SHIFT;
        sreg      <= data_in;
        cnt       <= '0;
        x         <= data_in[WIDTH-1];
        x_valid   <= 1'b1;
        word_done <= 1'b0;
`ifdef PARITY_BIT_EN
        par       <= ^data_in;
`endif
      end else begin
        case (state)
          SHIFT: begin
            if (last_data) begin
`ifdef PARITY_BIT_EN
              state     <= PARITY;
              x         <= par;
              word_done <= 1'b1;
`else
              state     <= IDLE;
              x         <= 1'b0;
              x_valid   <= 1'b0;
              word_done <= 1'b0;
`endif
            end else begin
              sreg <= {sreg[WIDTH-2:0], 1'b0};
              x    <= sreg[WIDTH-2];
              cnt  <= cnt + CW'(1);
`ifdef PARITY_BIT_EN
              word_done <= 1'b0;
`else
              // Pulse lands with the final bit, so it is set one shift early.
              word_done <= (cnt == CW'(WIDTH-2));
`endif
            end
          end
`ifdef PARITY_BIT_EN
          PARITY: begin
            state     <= IDLE;
            x         <= 1'b0;
            x_valid   <= 1'b0;
            word_done <= 1'b0;
          end
`endif
          default: begin
            state     <= IDLE;
            x         <= 1'b0;
            x_valid   <= 1'b0;
            word_done <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
